// File: rtl/tlc_phase_scheduler.sv
// Two-road intersection phase scheduler: green/yellow/all-red sequencing with
// min/max green, latched pedestrian requests and a tick-driven phase timer.
module tlc_phase_scheduler #(
    parameter int unsigned T_GREEN_MIN = 20,
    parameter int unsigned T_GREEN_MAX = 40,
    parameter int unsigned T_YELLOW    = 5,
    parameter int unsigned T_ALLRED    = 2,
    parameter int unsigned T_WALK      = 10,
    parameter int unsigned W           = 6
) (
    input  logic         clk,
    input  logic         res_n,
    input  logic         tick,
    input  logic         s_a,
    input  logic         s_b,
    input  logic         p_a,
    input  logic         p_b,
    output logic         Ga,
    output logic         Ya,
    output logic         Ra,
    output logic         Gb,
    output logic         Yb,
    output logic         Rb,
    output logic         walk_a,
    output logic         walk_b,
    output logic [W-1:0] t,
    output logic [2:0]   phase
);

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        A_CLEAR  = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        B_CLEAR  = 3'd5
    } state_t;

    localparam logic [W:0]   GMIN_R   = (W+1)'(T_GREEN_MIN);
    localparam logic [W:0]   GMAX_R   = (W+1)'(T_GREEN_MAX);
    localparam logic [W:0]   YEL_R    = (W+1)'(T_YELLOW);
    localparam logic [W:0]   ALLRED_R = (W+1)'(T_ALLRED);
    localparam logic [W-1:0] T_SAT    = W'(T_GREEN_MAX - 1);
    localparam logic [W-1:0] WALK_T   = W'(T_WALK);

    state_t       state, state_nxt;
    logic [W-1:0] t_nxt;
    logic [W:0]   t_run;
    logic         pend_a, pend_b, wflag_a, wflag_b;
    logic         dem_a, dem_b, enter_a, enter_b;

    always_comb begin
        dem_a     = s_a | pend_a;
        dem_b     = s_b | pend_b;
        t_run     = {1'b0, t} + 1'b1;
        state_nxt = state;
        case (state)
            A_GREEN:  if (tick && t_run >= GMIN_R && dem_b && (!s_a || t_run >= GMAX_R))
                          state_nxt = A_YELLOW;
            A_YELLOW: if (tick && t_run == YEL_R)    state_nxt = A_CLEAR;
            A_CLEAR:  if (tick && t_run == ALLRED_R) state_nxt = B_GREEN;
            B_GREEN:  if (tick && t_run >= GMIN_R && dem_a && (!s_b || t_run >= GMAX_R))
                          state_nxt = B_YELLOW;
            B_YELLOW: if (tick && t_run == YEL_R)    state_nxt = B_CLEAR;
            B_CLEAR:  if (tick && t_run == ALLRED_R) state_nxt = A_GREEN;
            default:  state_nxt = A_GREEN;
        endcase

        // Illegal-code recovery changes state without a tick, so it also zeroes t.
        if (state_nxt != state)
            t_nxt = '0;
        else if (tick && t != T_SAT)
            t_nxt = t + 1'b1;
        else
            t_nxt = t;

        enter_a = (state_nxt == A_GREEN) && (state != A_GREEN);
        enter_b = (state_nxt == B_GREEN) && (state != B_GREEN);
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state   <= A_GREEN;
            t       <= '0;
            pend_a  <= 1'b0;
            pend_b  <= 1'b0;
            wflag_a <= 1'b0;
            wflag_b <= 1'b0;
        end else begin
            state <= state_nxt;
            t     <= t_nxt;
            if (enter_a) begin
                wflag_a <= pend_a | p_a;
                pend_a  <= 1'b0;
            end else begin
                pend_a  <= pend_a | p_a;
            end
            if (enter_b) begin
                wflag_b <= pend_b | p_b;
                pend_b  <= 1'b0;
            end else begin
                pend_b  <= pend_b | p_b;
            end
        end
    end

    always_comb begin
        {Ga, Ya, Ra, Gb, Yb, Rb} = '0;
        case (state)
            A_GREEN:  begin Ga = 1'b1; Rb = 1'b1; end
            A_YELLOW: begin Ya = 1'b1; Rb = 1'b1; end
            B_GREEN:  begin Ra = 1'b1; Gb = 1'b1; end
            B_YELLOW: begin Ra = 1'b1; Yb = 1'b1; end
            default:  begin Ra = 1'b1; Rb = 1'b1; end
        endcase
        phase  = state;
        walk_a = (state == A_GREEN) && wflag_a && (t < WALK_T);
        walk_b = (state == B_GREEN) && wflag_b && (t < WALK_T);
    end

endmodule

// File: doc/tlc_phase_scheduler.md
# tlc_phase_scheduler

Phase scheduler for a two-road intersection. It sequences A/B green, yellow and all-red clearance from vehicle sensors and latched pedestrian requests, enforcing minimum and maximum green times. It also keeps its own tick-driven phase timer and drives the six lamp outputs plus per-road walk signals. It is the next-generation replacement for the fsm-plus-timer pairing at the top of the traffic light controller.

## Interface
- T_GREEN_MIN, 20: minimum green length in ticks.
- T_GREEN_MAX, 40: maximum green length in ticks when the other road has demand.
- T_YELLOW, 5: yellow length in ticks.
- T_ALLRED, 2: all-red clearance length in ticks.
- T_WALK, 10: walk window length in ticks. Constraint: 1 ≤ T_WALK ≤ T_GREEN_MIN.
- W, 6: phase timer width. Constraint: 2^W > T_GREEN_MAX.
- clk  in  1  single clock, rising edge.
- res_n  in  1  reset, synchronous, active-low.
- tick  in  1  time-base enable, one-cycle pulse. All timing advances only on clock edges where tick=1.
- s_a, s_b  in  1  vehicle presence on road A/B, level.
- p_a, p_b  in  1  pedestrian button for walking alongside road A/B; pulse or level, sampled every clock.
- Ga, Ya, Ra, Gb, Yb, Rb  out  1  lamp drives.
- walk_a, walk_b  out  1  walk lamps.
- t  out  W  elapsed ticks in current phase.
- phase  out  3  current state encoding.

## Operation
- States and phase encoding:
  - 0 A_GREEN, 1 A_YELLOW, 2 A_CLEAR
  - 3 B_GREEN, 4 B_YELLOW, 5 B_CLEAR
  - Codes 6 and 7 are illegal and recover to A_GREEN with t=0 on the next clock.
- Demand: dem_a = s_a | pend_a; dem_b = s_b | pend_b.
- A_GREEN -> A_YELLOW on a tick edge when both hold:
  - t+1 ≥ T_GREEN_MIN and dem_b;
  - and either !s_a or t+1 ≥ T_GREEN_MAX.
  - B_GREEN -> B_YELLOW is symmetric, with the A/B roles swapped.
- Without demand from the other road, green holds indefinitely.
  - t saturates at T_GREEN_MAX-1 and never wraps.
  - If demand then appears while t is saturated, the phase leaves on the next tick.
- x_YELLOW -> x_CLEAR on a tick edge with t == T_YELLOW-1.
- x_CLEAR -> the other road's GREEN on a tick edge with t == T_ALLRED-1.
- Timer behaviour:
  - On a tick edge that changes state, t <= 0.
  - On any other tick edge, t increments (saturating as above).
  - Without a tick, t holds.
- Lamps are Moore-decoded from state:
  - A_GREEN: Ga=1, Rb=1.
  - A_YELLOW: Ya=1, Rb=1.
  - A_CLEAR: Ra=1, Rb=1.
  - B states mirror the A states.
  - Exactly one lamp per road is high at all times.
- Pedestrian latch:
  - Every clock: pend_x <= pend_x | p_x, except on the edge entering x_GREEN.
  - On the edge entering x_GREEN: walk_flag_x <= pend_x | p_x and pend_x <= 0. A press coincident with entry is served in that green.
  - A press during x_GREEN (after entry) stays latched and is served in the next x_GREEN. It also counts toward dem_x.
- walk_x = (state == x_GREEN) & walk_flag_x & (t < T_WALK).
- walk_a and walk_b are never both high.

## Timing
- Reset (res_n=0 at a clock edge, any state, with or without tick):
  - state A_GREEN, t=0, phase=0.
  - Ga=1, Rb=1; Ya=Ra=Gb=Yb=0.
  - walk_a=walk_b=0; pend and walk flags cleared.
- Reset takes priority over tick.
- All outputs are registered or decoded from registers only, with no combinational input-to-output path.
- A qualifying tick edge updates state and outputs in the following cycle (1-cycle latency).
- Sensor changes are seen at the next tick edge. No debouncing is done in this block.
- Phase lengths in ticks:
  - Green: between T_GREEN_MIN and T_GREEN_MAX when the other road has demand.
  - Yellow: exactly T_YELLOW.
  - All-red clearance: exactly T_ALLRED.

## Test plan
Test plan uses overrides T_GREEN_MIN=4, T_GREEN_MAX=8, T_YELLOW=2, T_ALLRED=1, T_WALK=3, with tick=1 every cycle unless stated.

- Reset, s_a=0, s_b=1 -> A_GREEN for t=0..3, A_YELLOW for 2 cycles, A_CLEAR for 1 cycle; Gb=1 at the 8th cycle after reset release (phase=3).
- s_a=s_b=1 constant -> greens last 8 ticks each; full cycle A_GREEN→A_GREEN takes 22 ticks; Ga/Gb never both high; exactly one lamp per road every cycle.
- No demand (all inputs 0) for 50 cycles -> phase stays 0 and t holds at 7. Then s_b=1 for 1 cycle -> A_YELLOW on the next tick.
- s_a=1, s_b=0, 1-cycle p_b pulse at A_GREEN t=1 -> A_GREEN lasts 8 ticks, then B_GREEN with walk_b=1 for t=0..2. B then leaves at t=3 (s_b=0, dem_a=1). A p_b pulse on the exact B_GREEN entry edge is served in that same window.
- tick gated low for 10 cycles mid-A_YELLOW -> t, phase and lamps frozen; the sequence resumes unchanged when tick returns.
- res_n=0 for 1 cycle during B_YELLOW with tick=1 -> next cycle shows phase=0, t=0, Ga=1, Rb=1, walk 0, pending requests cleared.
